// File: rtl/mips_multicycle_ctrl_if.sv
// Memory handshake between the multicycle controller and the shared
// instruction/data memory.
//
// Signals:
//   mem_req    controller -> memory  request valid, held until mem_ready
//   mem_read   controller -> memory  read request (qualified by mem_req)
//   mem_write  controller -> memory  write request (qualified by mem_req)
//   i_or_d     controller -> memory  0 = PC addresses memory, 1 = ALU-out
//   mem_ready  memory -> controller  current request completes this cycle
//
// Modports: master (controller side), slave (memory side).
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_read,
        output mem_write,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_read,
        input  mem_write,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences the datapath through
// FETCH/DECODE/EXEC/MEM/WB steps, drives the memory request handshake and
// keeps retired-instruction and memory-stall counters.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   mem           memory handshake (master modport of mips_multicycle_ctrl_if)
//   opcode        instruction[31:26] from the instruction register
//   zero_flag     ALU zero result (the datapath gates pc_write_cond with it)
//   ir_write      load instruction register
//   pc_write      unconditional PC load
//   pc_write_cond PC load if zero_flag
//   pc_source     00 ALU result, 01 ALU-out register, 10 jump target
//   alu_src_a     0 = PC, 1 = rs data
//   alu_src_b     00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   alu_op        00 add, 01 sub, 10 funct-decoded
//   reg_dst       0 = rt, 1 = rd
//   mem_to_reg    0 = ALU-out, 1 = memory data
//   reg_write     register file write enable
//   instr_done    one-cycle pulse in the retire cycle
//   retired_cnt   retired instructions (wraps)
//   stall_cnt     cycles spent waiting on mem_ready (wraps)
//   trap          illegal opcode seen
//
// Build option: define MIPS_CTRL_ILLEGAL_TRAP_EN to make an undecoded opcode
// park the FSM in a trap state until reset. Without it an undecoded opcode
// retires as a one-cycle NOP and trap is always 0.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master mem,
    input  logic [5:0]             opcode,
    input  logic                   zero_flag,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_source,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   instr_done,
    output logic [CNT_W-1:0]       retired_cnt,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic                   trap
);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StBranch,
        StJump,
        StIllegal
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, stall_q;
    logic             stall_inc;

    // The branch decision is taken in the datapath from pc_write_cond and
    // zero_flag, so the controller itself never needs the flag.
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, instr_done};
            stall_q   <= stall_q + {{(CNT_W-1){1'b0}}, stall_inc};
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;

    always_comb begin
        state_d       = state_q;
        mem.mem_req   = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.i_or_d    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        trap          = 1'b0;
        stall_inc     = 1'b0;

        case (state_q)
            StIdle: state_d = StFetch;

            StFetch: begin
                mem.mem_req  = 1'b1;
                mem.mem_read = 1'b1;
                alu_src_b    = 2'b01;  // PC + 4
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    stall_inc = 1'b1;
                end
            end

            StDecode: begin
                alu_src_b = 2'b11;  // branch target precompute into ALU-out
                case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpRType:    state_d = StRExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StIExec;
                    default:    state_d = StIllegal;
                endcase
            end

            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only LW and SW reach here; the IR holds opcode stable.
                state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
            end

            StMemRd: begin
                mem.mem_req  = 1'b1;
                mem.mem_read = 1'b1;
                mem.i_or_d   = 1'b1;
                if (mem.mem_ready) begin
                    state_d = StMemWb;
                end else begin
                    stall_inc = 1'b1;
                end
            end

            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StMemWr: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                mem.i_or_d    = 1'b1;
                if (mem.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end else begin
                    stall_inc = 1'b1;
                end
            end

            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StRWb;
            end

            StRWb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StIWb;
            end

            StIWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = StFetch;
            end

            StJump: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StIllegal: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                // Parked until reset: no retire, no counting.
                trap    = 1'b1;
                state_d = StIllegal;
`else
                // Undecoded opcode retires as a NOP.
                instr_done = 1'b1;
                state_d    = StFetch;
`endif
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;  // small so both counters wrap during the run

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // One cycle's worth of expected control outputs.
    typedef struct packed {
        logic       req;
        logic       rd;
        logic       wr;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       done;
        logic       trap;
    } ctl_t;

    typedef struct packed {
        ctl_t             c;
        logic [CNT_W-1:0] ret;
        logic [CNT_W-1:0] stl;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic             zero_flag;
    logic             ir_write, pc_write, pc_write_cond;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b, alu_op;
    logic             reg_dst, mem_to_reg, reg_write, instr_done, trap;
    logic [CNT_W-1:0] retired_cnt, stall_cnt;

    mips_multicycle_ctrl_if mif ();

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (mif),
        .opcode       (opcode),
        .zero_flag    (zero_flag),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source    (pc_source),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .instr_done   (instr_done),
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt),
        .trap         (trap)
    );

    int               n_tests = 0;
    int               n_fail  = 0;
    int               step    = 0;
    bit               mon_en  = 0;
    exp_t             exp_q[$];
    int               ready_q[$];   // wait cycles per memory request
    logic [CNT_W-1:0] m_ret, m_stall;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic ctl_t sample_ctl();
        ctl_t a;
        a.req   = mif.mem_req;
        a.rd    = mif.mem_read;
        a.wr    = mif.mem_write;
        a.iord  = mif.i_or_d;
        a.irw   = ir_write;
        a.pcw   = pc_write;
        a.pcwc  = pc_write_cond;
        a.pcsrc = pc_source;
        a.srca  = alu_src_a;
        a.srcb  = alu_src_b;
        a.aluop = alu_op;
        a.rdst  = reg_dst;
        a.m2r   = mem_to_reg;
        a.rw    = reg_write;
        a.done  = instr_done;
        a.trap  = trap;
        return a;
    endfunction

    // Memory model: answers each request after the queued number of waits.
    initial begin
        mif.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                mif.mem_ready = 1'b0;
            end else if (mif.mem_req) begin
                if (ready_q.size() == 0) begin
                    mif.mem_ready = 1'b0;
                end else if (ready_q[0] == 0) begin
                    mif.mem_ready = 1'b1;
                    void'(ready_q.pop_front());
                end else begin
                    ready_q[0]    = ready_q[0] - 1;
                    mif.mem_ready = 1'b0;
                end
            end else begin
                mif.mem_ready = 1'($urandom);  // must be ignored
            end
        end
    end

    // Monitor: one expected entry per clock cycle while enabled.
    initial begin
        ctl_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                act = sample_ctl();
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow step %0d: got ctl=%h, required no DUT cycle",
                             step, act);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (act !== e.c) begin
                        n_fail++;
                        $display("FAIL ctl step %0d: got %h required %h", step, act, e.c);
                    end
                    n_tests++;
                    if (retired_cnt !== e.ret) begin
                        n_fail++;
                        $display("FAIL retired_cnt step %0d: got %0d required %0d",
                                 step, retired_cnt, e.ret);
                    end
                    n_tests++;
                    if (stall_cnt !== e.stl) begin
                        n_fail++;
                        $display("FAIL stall_cnt step %0d: got %0d required %0d",
                                 step, stall_cnt, e.stl);
                    end
                end
                step++;
            end
        end
    end

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic push_word(input ctl_t c, input bit stall);
        exp_t e;
        e.c   = c;
        e.ret = m_ret;
        e.stl = m_stall;
        exp_q.push_back(e);
        if (stall)  m_stall = m_stall + 1'b1;
        if (c.done) m_ret   = m_ret + 1'b1;
    endtask

    // Reference: cycle-by-cycle control words of one instruction, built from
    // the step table for its opcode class, f fetch waits and m data waits.
    task automatic gen(input logic [5:0] op, input int f, input int m);
        ctl_t w;
        for (int i = 0; i <= f; i++) begin
            w = '0; w.req = 1; w.rd = 1; w.srcb = 2'b01;
            if (i == f) begin w.irw = 1; w.pcw = 1; end
            push_word(w, i < f);
        end
        w = '0; w.srcb = 2'b11;
        push_word(w, 0);
        case (op)
            OP_LW, OP_SW: begin
                w = '0; w.srca = 1; w.srcb = 2'b10;
                push_word(w, 0);
                for (int i = 0; i <= m; i++) begin
                    w = '0; w.req = 1; w.iord = 1;
                    if (op == OP_LW) w.rd = 1;
                    else             w.wr = 1;
                    if (op == OP_SW && i == m) w.done = 1;
                    push_word(w, i < m);
                end
                if (op == OP_LW) begin
                    w = '0; w.rw = 1; w.m2r = 1; w.done = 1;
                    push_word(w, 0);
                end
            end
            OP_R: begin
                w = '0; w.srca = 1; w.aluop = 2'b10;
                push_word(w, 0);
                w = '0; w.rw = 1; w.rdst = 1; w.done = 1;
                push_word(w, 0);
            end
            OP_ADDI: begin
                w = '0; w.srca = 1; w.srcb = 2'b10;
                push_word(w, 0);
                w = '0; w.rw = 1; w.done = 1;
                push_word(w, 0);
            end
            OP_BEQ: begin
                w = '0; w.srca = 1; w.aluop = 2'b01; w.pcwc = 1; w.pcsrc = 2'b01; w.done = 1;
                push_word(w, 0);
            end
            OP_J: begin
                w = '0; w.pcw = 1; w.pcsrc = 2'b10; w.done = 1;
                push_word(w, 0);
            end
            default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++) begin
                    w = '0; w.trap = 1;
                    push_word(w, 0);
                end
`else
                w = '0; w.done = 1;
                push_word(w, 0);
`endif
            end
        endcase
    endtask

    task automatic wait_drain();
        int budget;
        budget = 400;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            budget--;
            if (budget == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
                finish_tb();
            end
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic zf, input int f, input int m);
        wait_drain();
        opcode    = op;
        zero_flag = zf;
        ready_q.push_back(f);
        if (op == OP_LW || op == OP_SW) ready_q.push_back(m);
        gen(op, f, m);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        m_ret   = '0;
        m_stall = '0;
        push_word('0, 0);  // IDLE cycle
        mon_en  = 1'b1;
    endtask

    task automatic check_zero(input string name);
        ctl_t act;
        act = sample_ctl();
        n_tests++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL %s_ctl: got %h required 0", name, act);
        end
        n_tests++;
        if (retired_cnt !== '0 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s_cnt: got retired=%0d stall=%0d required 0/0",
                     name, retired_cnt, stall_cnt);
        end
    endtask

    task automatic abort_test();
        int budget;
        issue(OP_SW, 0, 0, 6);
        budget = 50;
        do begin
            @(negedge clk);
            budget--;
        end while (mif.mem_write !== 1'b1 && budget > 0);
        n_tests++;
        if (mif.mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_memwr: got mem_write=%b required 1", mif.mem_write);
            finish_tb();
        end
        repeat (2) @(negedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_zero("abort");
        exp_q.delete();
        ready_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_zero("abort_hold");
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        reset     = 1'b0;
        opcode    = OP_R;
        zero_flag = 1'b0;
        m_ret     = '0;
        m_stall   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        release_reset();
        issue(OP_R,    0, 0, 0);
        issue(OP_LW,   0, 3, 2);
        issue(OP_BEQ,  1, 0, 0);
        issue(OP_BEQ,  0, 0, 0);
        issue(OP_SW,   0, 0, 2);
        issue(OP_J,    0, 0, 0);
        issue(OP_ADDI, 1, 1, 0);
        abort_test();

        release_reset();
        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 5)];
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
`endif
            issue(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        issue(OP_BAD, 0, 1, 0);
        wait_drain();
        mon_en = 1'b0;
        finish_tb();
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the MIPS datapath (PC, instruction/data memory, register file, ALU, muxes) over multiple cycles per instruction.
- Replaces the per-cycle opcode decode with explicit FETCH/DECODE/EXEC/MEM/WB steps.
- Drives a ready/request handshake to the shared instruction/data memory.
- Keeps retired-instruction and stall counters.

Parameters:
- CNT_W, 32, width of the retired-instruction and stall counters (wrap modulo 2^CNT_W)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- zero_flag  in  1  ALU zero result
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_read  out  1  read request (with mem_req)
- mem_write  out  1  write request (with mem_req)
- i_or_d  out  1  0 = PC addresses memory, 1 = ALU-out addresses memory
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero_flag
- pc_source  out  2  00 ALU result, 01 ALU-out register, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = rs data
- alu_src_b  out  2  00 rt data, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU-out, 1 = memory data
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired_cnt  out  CNT_W  retired instructions
- stall_cnt  out  CNT_W  cycles spent waiting on mem_ready
- trap  out  1  illegal opcode seen (see Optional Feature)

Behaviour:
- Decoded opcodes:
  - R-type 000000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
  - ADDI 001000
- Reset (reset=0, async):
  - State goes to IDLE; all outputs and both counters are 0.
  - IDLE lasts exactly one cycle after reset deasserts, then goes to FETCH.
- FETCH:
  - Asserts mem_req, mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - While mem_ready=0: stay in FETCH, increment stall_cnt.
  - On the mem_ready=1 cycle: pulse ir_write=1 and pc_write=1 (Mealy on mem_ready), then go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: LW/SW go to MEM_ADDR, R-type to R_EXEC, BEQ to BRANCH, J to JUMP, ADDI to I_EXEC, any other to ILLEGAL handling.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD: mem_req=1, mem_read=1, i_or_d=1. Waits on mem_ready (stall_cnt counts), then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retires, then goes to FETCH.
- MEM_WR: mem_req=1, mem_write=1, i_or_d=1. Retires on the mem_ready=1 cycle, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00, then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires, then FETCH.
- JUMP: pc_write=1, pc_source=10. Retires, then FETCH.
- Retire cycle:
  - instr_done=1 for exactly one cycle.
  - retired_cnt increments on the following edge.
- Every control output not named in a state is 0 in that state.
- mem_req never drops while a request is outstanding.
- Latency with mem_ready always 1:
  - 3 cycles: BEQ, J
  - 4 cycles: R-type, ADDI, SW
  - 5 cycles: LW
- Counter wrap: retired_cnt and stall_cnt wrap from all-ones to 0 with no flag.
- Reset mid-instruction: aborts immediately; no further pc_write, reg_write or mem_write is issued.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An undecoded opcode in DECODE goes to TRAP.
  - TRAP holds trap=1 and all other controls 0, and stays there until reset.
  - No retire and no counter increments while in TRAP.
- Not defined:
  - An undecoded opcode behaves as NOP: one NOP cycle (all controls 0, instr_done=1), then FETCH.
  - trap is tied to 0.

Test Plan:
- Release reset, mem_ready tied 1, opcode=000000 -> IDLE 1 cycle; FETCH, DECODE, R_EXEC, R_WB; instr_done on cycle 5 after reset; reg_dst=1, reg_write=1 in R_WB; retired_cnt=1.
- LW (100011) with mem_ready low for 3 cycles in FETCH and 2 in MEM_RD -> ir_write/pc_write pulse only on ready cycle; stall_cnt=5; mem_to_reg=1 in MEM_WB; retired_cnt=1.
- BEQ (000100) with zero_flag=1, then BEQ with zero_flag=0 -> pc_write_cond=1 and pc_source=01 in BRANCH both times; 3-cycle latency each; retired_cnt=2.
- SW (101011) then J (000010) -> mem_write=1 with i_or_d=1 until mem_ready; reg_write never 1; J asserts pc_write=1, pc_source=10; retired_cnt=2.
- Assert reset in MEM_WR with mem_ready=0 -> all outputs 0 in the same cycle; counters 0; IDLE then FETCH after release.
- Opcode 111111 -> with macro: trap=1 held for 10 cycles, retired_cnt unchanged; without macro: instr_done pulse, back to FETCH, trap=0.
